// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch handshake between fetch_stage and imem.
// Request/address are held until the cycle ready is returned.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// PC register and IF/ID pipeline register with a variable-latency
// imem handshake, ID stall absorption and flush/drain handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  fetch_stage_if.master imem,
  output logic [31:0] pc,
  output logic [31:0] pre_pc,
  output logic [31:0] id_instr,
  output logic        id_valid
);

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_DRAIN
  } state_e;

  state_e      state_q;
  state_e      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pre_pc_q;
  logic [31:0] pre_pc_d;
  logic [31:0] id_instr_q;
  logic [31:0] id_instr_d;
  logic        id_valid_q;
  logic        id_valid_d;
  logic [31:0] hold_q;
  logic [31:0] hold_d;
  logic [31:0] drain_q;
  logic [31:0] drain_d;

  logic [31:0] npc_al;
  logic [31:0] fpc_al;
  logic        ready;

  assign npc_al = npc & ~32'h3;
  assign fpc_al = flush_pc & ~32'h3;
  assign ready  = imem.imem_ready;

  // Request is gated by reset so nothing issues while rst_n is low.
  assign imem.imem_req  = rst_n && (state_q != S_HOLD);
  assign imem.imem_addr = (state_q == S_DRAIN) ? drain_q : pc_q;

  assign pc       = pc_q;
  assign pre_pc   = pre_pc_q;
  assign id_instr = id_instr_q;
  assign id_valid = id_valid_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pre_pc_d   = pre_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    hold_d     = hold_q;
    drain_d    = drain_q;

    unique case (state_q)
      S_REQ: begin
        if (flush) begin
          pc_d       = fpc_al;
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
          if (!ready) begin
            drain_d = pc_q;
            state_d = S_DRAIN;
          end
        end else if (ready && !stall) begin
          id_instr_d = imem.imem_rdata;
          id_valid_d = 1'b1;
          pre_pc_d   = pc_q;
          pc_d       = npc_al;
        end else if (ready) begin
          hold_d  = imem.imem_rdata;
          state_d = S_HOLD;
        end else if (!stall) begin
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (flush) begin
          pc_d       = fpc_al;
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
          hold_d     = 32'h0;
          state_d    = S_REQ;
        end else if (!stall) begin
          id_instr_d = hold_q;
          id_valid_d = 1'b1;
          pre_pc_d   = pc_q;
          pc_d       = npc_al;
          state_d    = S_REQ;
        end
      end

      S_DRAIN: begin
        if (flush) begin
          pc_d       = fpc_al;
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
        end else if (!stall) begin
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
        end
        // Aborted response returns; its data is simply dropped.
        if (ready) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      pre_pc_q   <= 32'h0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      hold_q     <= 32'h0;
      drain_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pre_pc_q   <= pre_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      hold_q     <= hold_d;
      drain_q    <= drain_d;
    end
  end

endmodule
